// File: rtl/i2s_rx.sv
// Standard-I2S slave receiver: oversamples BCLK/LRCLK/DIN in the MCLK domain and
// deserialises MSB-first slots into a left/right word pair with a one-cycle strobe.
module i2s_rx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              MCLK,
  input  logic              MRST,
  input  logic              BCLK,
  input  logic              LRCLK,
  input  logic              DIN,
  output logic [DATA_W-1:0] DOUT_L,
  output logic [DATA_W-1:0] DOUT_R,
  output logic              VALID,
  output logic              FRAME_ERR,
  output logic [1:0]        fsm_state
);

  localparam int CNT_W = $clog2(DATA_W + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {HUNT = 2'd0, CAPTURE = 2'd1, WAIT = 2'd2} state_t;

  state_t                   state, state_nxt;
  logic [1:0]               rst_pipe;
  logic                     rst_n;
  logic [SYNC_STAGES-1:0]   bclk_sync, lr_sync, din_sync;
  logic                     bclk_s, lr_s, din_s, bclk_d, lr_prev;
  logic [CNT_W-1:0]         cnt;
  logic [DATA_W-1:0]        shreg, left_hold, word;
  logic                     left_ok;
  logic                     rise, slot_start, shift_en, word_done, short_slot;

  // Reset asserts asynchronously but releases on an MCLK edge.
  always_ff @(posedge MCLK or negedge MRST) begin
    if (!MRST) rst_pipe <= 2'b00;
    else       rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      din_sync  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], BCLK};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], LRCLK};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], DIN};
    end
  end

  assign bclk_s = bclk_sync[SYNC_STAGES-1];
  assign lr_s   = lr_sync[SYNC_STAGES-1];
  assign din_s  = din_sync[SYNC_STAGES-1];

  // cnt counts data bits already shifted in the current slot; the slot-start
  // edge carries the one-bit delay and never shifts.
  assign rise       = bclk_s & ~bclk_d;
  assign slot_start = rise & (lr_s != lr_prev);
  assign shift_en   = rise & ~slot_start & (cnt < CNT_FULL);
  assign word_done  = shift_en & (state == CAPTURE) & (cnt == CNT_LAST);
  assign short_slot = slot_start & (state == CAPTURE) & (cnt < CNT_FULL);
  assign word       = {shreg[DATA_W-2:0], din_s};
  assign fsm_state  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (slot_start) state_nxt = CAPTURE;
      CAPTURE: if (word_done)  state_nxt = WAIT;
      WAIT:    if (slot_start) state_nxt = CAPTURE;
      default: state_nxt = HUNT;
    endcase
  end

  // VALID is a one-MCLK strobe with no back-pressure: DOUT_L/DOUT_R change only
  // on the cycle VALID is high and hold until the next strobe.
  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      bclk_d    <= 1'b0;
      lr_prev   <= 1'b0;
      cnt       <= '0;
      shreg     <= '0;
      left_hold <= '0;
      left_ok   <= 1'b0;
      DOUT_L    <= '0;
      DOUT_R    <= '0;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      state     <= state_nxt;
      bclk_d    <= bclk_s;
      VALID     <= 1'b0;
      FRAME_ERR <= short_slot;
      if (rise) lr_prev <= lr_s;
      if (slot_start)               cnt <= '0;
      else if (rise && cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      if (shift_en) shreg <= word;
      if (short_slot) left_ok <= 1'b0;
      if (word_done) begin
        if (!lr_s) begin
          left_hold <= word;
          left_ok   <= 1'b1;
        end else if (left_ok) begin
          DOUT_L  <= left_hold;
          DOUT_R  <= word;
          VALID   <= 1'b1;
          left_ok <= 1'b0;
        end
      end
    end
  end

endmodule
